// File: rtl/mac_seq.sv
// mac_seq: sequences one vector of x/y pairs into the external MAC stage and captures its dot product.
// Latency: res_valid rises the cycle after the last pair is accepted; len=0 gives a zero result the cycle after start.
// Backpressure: in_valid may stall anywhere in RUN; the result is held stable in DONE until res_ready.
//
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   start, len, busy      command: begin a vector of len pairs (sampled in IDLE only); busy in RUN/DONE
//   in_valid/in_ready     operand stream handshake, in_x / in_y operands
//   mac_en/mac_clr        accumulator control; mac_x / mac_y operand pass-through
//   mac_out               accumulator value including the current product (combinational)
//   res_valid/res_ready   result handshake, res_data dot product
//   stall_cnt             (only with MAC_SEQ_STALL_CNT_EN) RUN cycles with in_valid low, saturating
//
// Optional feature macro: MAC_SEQ_STALL_CNT_EN

module mac_seq #(
  parameter int X_WIDTH   = 43,
  parameter int Y_WIDTH   = 43,
  parameter int OUT_WIDTH = 43,
  parameter int LEN_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [X_WIDTH-1:0]   in_x,
  input  logic [Y_WIDTH-1:0]   in_y,
  output logic                 mac_en,
  output logic                 mac_clr,
  output logic [X_WIDTH-1:0]   mac_x,
  output logic [Y_WIDTH-1:0]   mac_y,
  input  logic [OUT_WIDTH-1:0] mac_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_WIDTH-1:0] res_data
`ifdef MAC_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       remaining_q, remaining_d;
  logic                   first_q, first_d;
  logic                   res_valid_q, res_valid_d;
  logic [OUT_WIDTH-1:0]   res_data_q, res_data_d;

  // Operands go straight through; the accumulator only looks at them when mac_en is high.
  assign mac_x     = in_x;
  assign mac_y     = in_y;
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    in_ready    = 1'b0;
    mac_en      = 1'b0;
    mac_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            remaining_d = len;
            first_d     = 1'b1;
            state_d     = RUN;
          end else begin
            // Empty vector: the dot product is zero, the accumulator is never touched.
            res_data_d  = '0;
            res_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end

      RUN: begin
        in_ready = 1'b1;
        mac_en   = in_valid;
        // Clear-and-load on the first pair throws away whatever the previous vector left behind.
        mac_clr  = first_q & in_valid;
        if (in_valid) begin
          remaining_d = remaining_q - 1'b1;
          first_d     = 1'b0;
          if (remaining_q == LEN_W'(1)) begin
            // mac_out already includes the product of the pair accepted this cycle.
            res_data_d  = mac_out;
            res_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end

      DONE: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      first_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt = stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE && start) begin
      stall_cnt_d = '0;
    end else if (state_q == RUN && !in_valid && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: drives vectors through mac_seq with a behavioural Q11.32 accumulator attached
// and checks results against a scoreboard of hand-computed dot products.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.

module tb_mac_seq;

  localparam int XW = 43;
  localparam int YW = 43;
  localparam int OW = 43;
  localparam int LW = 16;

  localparam logic [42:0] ONE   = 43'h001_0000_0000;
  localparam logic [42:0] TWO   = 43'h002_0000_0000;
  localparam logic [42:0] THREE = 43'h003_0000_0000;
  localparam logic [42:0] FOUR  = 43'h004_0000_0000;
  localparam logic [42:0] SEVEN = 43'h007_0000_0000;
  localparam logic [42:0] HALF  = 43'h000_8000_0000;
  localparam logic [42:0] ONEP5 = 43'h001_8000_0000;
  localparam logic [42:0] NEG1  = 43'h7FF_0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;
  logic          mac_en;
  logic          mac_clr;
  logic [XW-1:0] mac_x;
  logic [YW-1:0] mac_y;
  logic [OW-1:0] mac_out;
  logic          res_valid;
  logic          res_ready;
  logic [OW-1:0] res_data;
`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  int clr_cnt  = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  mac_seq #(.X_WIDTH(XW), .Y_WIDTH(YW), .OUT_WIDTH(OW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_x(mac_x), .mac_y(mac_y),
    .mac_out(mac_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
`ifdef MAC_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Behavioural accumulator: Q11.32 product truncated back to 43 bits, plus the running sum.
  // It is deliberately not reset so a missing clear leaves a stale value in the result.
  logic signed [85:0] prod;
  logic [42:0]        acc_q = '0;
  assign prod    = $signed(mac_x) * $signed(mac_y);
  assign mac_out = (mac_clr ? 43'd0 : acc_q) + prod[74:32];
  always @(posedge clk) if (mac_en) acc_q <= mac_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every completed result handshake pops one expected dot product.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) check("sb_unexpected_result", 64'(res_data), 64'hDEAD);
      else check("res_data", 64'(res_data), sb.pop_front());
    end
    if (mac_en)  en_cnt++;
    if (mac_clr) clr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_vec(input int l, input logic [42:0] exp, input bit push);
    start = 1'b1;
    len   = LW'(l);
    if (push) sb.push_back(64'(exp));
    tick();
    start = 1'b0;
  endtask

  task automatic send_pair(input string tag, input logic [42:0] x, input logic [42:0] y,
                           input bit exp_clr);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_mac_en"},   64'(mac_en),   64'd1);
    check({tag, "_mac_clr"},  64'(mac_clr),  64'(exp_clr));
    check({tag, "_mac_x"},    64'(mac_x),    64'(x));
    tick();
    in_valid = 1'b0;
  endtask

  // Result must be up on the cycle after the last accept; res_ready=1 completes it at the next edge.
  task automatic expect_result(input string tag, input int exp_stall);
    @(negedge clk);
    check({tag, "_res_valid_lat"}, 64'(res_valid), 64'd1);
    check({tag, "_in_ready_done"}, 64'(in_ready),  64'd0);
`ifdef MAC_SEQ_STALL_CNT_EN
    if (exp_stall >= 0) check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(exp_stall));
`endif
    tick();
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int en0, clr0;
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_x = '0; in_y = '0; res_ready = 1'b1;
    #1;
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data",  64'(res_data),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
`ifdef MAC_SEQ_STALL_CNT_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    tick(); tick();
    rst = 1'b0;
    tick();

    // len=3: 1*2 + 0.5*4 + (-1)*1 = 3.0
    en0 = en_cnt; clr0 = clr_cnt;
    start_vec(3, THREE, 1'b1);
    check("v1_busy", 64'(busy), 64'd1);
    send_pair("v1p1", ONE,  TWO,  1'b1);
    send_pair("v1p2", HALF, FOUR, 1'b0);
    send_pair("v1p3", NEG1, ONE,  1'b0);
    expect_result("v1", -1);
    check("v1_en_cycles",  64'(en_cnt - en0),   64'd3);
    check("v1_clr_cycles", 64'(clr_cnt - clr0), 64'd1);

    // Back-to-back len=2 vectors of (1,1): each 2.0, second must clear again.
    for (int v = 0; v < 2; v++) begin
      start_vec(2, TWO, 1'b1);
      send_pair("b2b_p1", ONE, ONE, 1'b1);
      send_pair("b2b_p2", ONE, ONE, 1'b0);
      expect_result("b2b", -1);
    end

    // len=4 with a two-cycle gap between pairs 2 and 3: 1+2+1+3 = 7.0
    start_vec(4, SEVEN, 1'b1);
    send_pair("gap_p1", ONE, ONE, 1'b1);
    send_pair("gap_p2", TWO, ONE, 1'b0);
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      check("gap_mac_en", 64'(mac_en), 64'd0);
      check("gap_busy",   64'(busy),   64'd1);
      tick();
    end
    send_pair("gap_p3", HALF,  TWO, 1'b0);
    send_pair("gap_p4", THREE, ONE, 1'b0);
    expect_result("gap", 2);

    // Result backpressure: 2*1.5 + 1*1 = 4.0 held for 5 cycles, starts ignored.
    res_ready = 1'b0;
    start_vec(2, FOUR, 1'b1);
    send_pair("bp_p1", TWO, ONEP5, 1'b1);
    send_pair("bp_p2", ONE, ONE,   1'b0);
    for (int c = 0; c < 5; c++) begin
      start = (c == 1 || c == 3);
      len   = LW'(3);
      @(negedge clk);
      check("bp_res_valid", 64'(res_valid), 64'd1);
      check("bp_res_data",  64'(res_data),  64'(FOUR));
      check("bp_in_ready",  64'(in_ready),  64'd0);
      check("bp_busy",      64'(busy),      64'd1);
      tick();
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", 64'(res_valid), 64'd1);
    tick();
    check("bp_busy_drop", 64'(busy), 64'd0);
    @(negedge clk);
    check("bp_no_stray_start", 64'(busy), 64'd0);
    tick();

    // len=0: zero result next cycle, no accumulator activity.
    en0 = en_cnt;
    start_vec(0, 43'd0, 1'b1);
    expect_result("len0", 0);
    check("len0_en_cycles", 64'(en_cnt - en0), 64'd0);

    // Reset after 2 of 5 pairs abandons the vector.
    start_vec(5, 43'd0, 1'b0);
    send_pair("rst_p1", ONE, ONE, 1'b1);
    send_pair("rst_p2", ONE, ONE, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy",      64'(busy),      64'd0);
    check("arst_in_ready",  64'(in_ready),  64'd0);
    check("arst_res_valid", 64'(res_valid), 64'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_res_valid", 64'(res_valid), 64'd0);
      tick();
    end
    start_vec(1, THREE, 1'b1);
    send_pair("rst_v1", THREE, ONE, 1'b1);
    expect_result("post_rst", 0);

    tick();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Sequencer directly upstream of the fixed-point multiply-accumulate stage. Also captures that stage's output.
- Accepts a start command with a vector length, then streams x/y operand pairs in with a valid/ready handshake.
- Drives the accumulator's en/clr/x/y so each vector yields one dot product.
- Latches the accumulated result and presents it downstream with a valid/ready handshake.

Parameters:
- X_WIDTH, 43, operand x width (signed fixed point, X_FRAC fractional bits; carried only for MAC port matching)
- Y_WIDTH, 43, operand y width (signed)
- OUT_WIDTH, 43, accumulator/result width (signed)
- LEN_W, 16, width of the vector-length field

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin a new vector; sampled only in IDLE
- len  in  LEN_W  element count, sampled with start
- busy  out  1  high in RUN or DONE
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid&in_ready
- in_x  in  X_WIDTH  operand x
- in_y  in  Y_WIDTH  operand y
- mac_en  out  1  accumulator enable
- mac_clr  out  1  accumulator clear-and-load
- mac_x  out  X_WIDTH  operand x to accumulator
- mac_y  out  Y_WIDTH  operand y to accumulator
- mac_out  in  OUT_WIDTH  accumulator feedback value (product plus acc, combinational on the current inputs)
- res_valid  out  1  result valid
- res_ready  in  1  downstream accept
- res_data  out  OUT_WIDTH  dot product

Behaviour:
- Reset, asynchronous, active-high. Effect: state=IDLE, count=0, first=0, res_valid=0, res_data=0, busy=0. Reset mid-vector abandons the vector; no result is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0.
  - start with len>0: latch remaining=len, set first=1, go to RUN.
  - start with len=0: res_data<=0, res_valid<=1, go to DONE (no accumulator activity).
- RUN:
  - in_ready=1.
  - Operand pass-through: mac_x=in_x, mac_y=in_y combinationally.
  - mac_en = in_valid&in_ready.
  - mac_clr = first & mac_en. This is the first accepted pair, which discards the stale accumulation.
  - Each accept: remaining decrements, first clears.
  - Accept with remaining==1 (last pair): res_data<=mac_out (same-cycle value including the last product), res_valid<=1, go to DONE.
  - in_valid low: no accept, mac_en=0, state holds (stalls allowed anywhere in the vector).
- DONE:
  - in_ready=0, mac_en=0.
  - res_valid&res_ready: res_valid<=0, go to IDLE.
  - res_data holds stable while res_valid=1.
- Latency: res_valid rises on the cycle after the last pair is accepted. Minimum vector period is len+2 cycles (start, len accepts, result handshake).
- start outside IDLE is ignored. A new start is accepted no earlier than the cycle after res_valid drops.
- len=2^LEN_W-1 must work (counter does not wrap).
- Width rules:
  - Arithmetic is fully in the accumulator; the sequencer never modifies data.
  - res_data is exactly mac_out bits; overflow wraps per the accumulator's truncation.
- mac_x, mac_y, mac_en, mac_clr are combinational from state and inputs, with no extra register stage.

Optional Feature:
- Macro: MAC_SEQ_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 16 bits.
  - Counts RUN cycles with in_valid=0, saturating at 16'hFFFF.
  - Cleared on reset and on each accepted start.
  - Frozen outside RUN and readable in DONE alongside res_data.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- len=3, pairs (1.0,2.0),(0.5,4.0),(-1.0,1.0) in Q11.32, in_valid constant:
  - mac_clr high only on pair 1; mac_en high 3 cycles.
  - res_valid one cycle after third accept; res_data = 3.0 (0x3_0000_0000).
- Back-to-back vectors, each len=2 with all pairs (1.0,1.0):
  - Second vector's first pair asserts mac_clr.
  - Both results = 2.0; no carry-over from vector 1.
- len=4 with in_valid low 2 cycles between pairs 2 and 3:
  - mac_en=0 during the gap; result unchanged vs. no-gap run.
  - With MAC_SEQ_STALL_CNT_EN: stall_cnt=2.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid:
  - res_data stable, in_ready=0.
  - start pulses during the hold are ignored.
  - Handshake completes in cycle 6; busy drops.
- len=0 start: res_valid next cycle with res_data=0; mac_en never asserts.
- Assert rst mid-vector after 2 of 5 pairs:
  - Outputs reset immediately (asynchronous); res_valid stays 0.
  - A following len=1 vector with (3.0,1.0) returns 3.0.
